// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencing controller for the 16-bit datapath: fetch/decode/execute/memory/
// writeback control strobes, retired-instruction counter and sticky halt/illegal status.
module multicycle_control_fsm #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic [6:0]       Opcode,
    input  logic             ALU_Zero,
    input  logic             Mem_Ready,
    output logic             IR_Write,
    output logic             PC_Write,
    output logic             PC_Write_Cond,
    output logic             IorD,
    output logic             Mem_Read,
    output logic             Mem_Write,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic [CNT_W-1:0] Retired,
    output logic             Halted,
    output logic             Illegal
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StAluWb,
        StMemAddr,
        StMemRd,
        StLoadWb,
        StMemWr,
        StBranch,
        StJump,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsRType  = 3'b000,
        ClsIType  = 3'b001,
        ClsLoad   = 3'b010,
        ClsStore  = 3'b011,
        ClsBranch = 3'b100,
        ClsJump   = 3'b101,
        ClsIllegl = 3'b110,
        ClsHalt   = 3'b111
    } class_e;

    state_e           state_q, state_d;
    logic             is_store_q, is_store_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    class_e           op_class;

    // Only the class field steers the sequence; the low bits belong to the datapath.
    logic unused_opcode_low;
    assign unused_opcode_low = ^Opcode[3:0];

    assign op_class = class_e'(Opcode[6:4]);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StFetch;
            is_store_q <= 1'b0;
            retired_q  <= '0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            retired_q  <= retired_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
        end
    end

    // Next state and control strobes.
    always_comb begin
        state_d       = state_q;
        is_store_d    = is_store_q;
        halted_d      = halted_q;
        illegal_d     = illegal_q;
        IR_Write      = 1'b0;
        PC_Write      = 1'b0;
        PC_Write_Cond = 1'b0;
        IorD          = 1'b0;
        Mem_Read      = 1'b0;
        Mem_Write     = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSource      = 2'b00;
        RegWrite      = 1'b0;
        MemtoReg      = 1'b0;

        unique case (state_q)
            StFetch: begin
                Mem_Read = 1'b1;
                ALUSrcB  = 2'b01;
                IR_Write = Mem_Ready;
                PC_Write = Mem_Ready;
                if (Mem_Ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                ALUSrcB    = 2'b10;
                // Opcode is only guaranteed stable here, so keep what MEM_ADDR needs.
                is_store_d = Opcode[4];
                unique case (op_class)
                    ClsRType:          state_d = StExecR;
                    ClsIType:          state_d = StExecI;
                    ClsLoad, ClsStore: state_d = StMemAddr;
                    ClsBranch:         state_d = StBranch;
                    ClsJump:           state_d = StJump;
                    ClsIllegl: begin
                        state_d   = StHalt;
                        halted_d  = 1'b1;
                        illegal_d = 1'b1;
                    end
                    ClsHalt: begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end
                    default:           state_d = StHalt;
                endcase
            end
            StExecR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b00;
                ALUOp   = 2'b10;
                state_d = StAluWb;
            end
            StExecI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                state_d  = StFetch;
            end
            StMemAddr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = is_store_q ? StMemWr : StMemRd;
            end
            StMemRd: begin
                Mem_Read = 1'b1;
                IorD     = 1'b1;
                if (Mem_Ready) begin
                    state_d = StLoadWb;
                end
            end
            StLoadWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = StFetch;
            end
            StMemWr: begin
                Mem_Write = 1'b1;
                IorD      = 1'b1;
                if (Mem_Ready) begin
                    state_d = StFetch;
                end
            end
            StBranch: begin
                ALUSrcA       = 1'b1;
                ALUOp         = 2'b01;
                PCSource      = 2'b01;
                PC_Write_Cond = 1'b1;
                PC_Write      = ALU_Zero;
                state_d       = StFetch;
            end
            StJump: begin
                PCSource = 2'b10;
                PC_Write = 1'b1;
                state_d  = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // An instruction retires when the sequence returns to FETCH from any other step.
    always_comb begin
        retired_d = retired_q;
        if (state_q != StFetch && state_d == StFetch) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    assign Retired = retired_q;
    assign Halted  = halted_q;
    assign Illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle strobe vectors, retired count and
// sticky status, plus a narrow-counter instance to reach the wrap point quickly.
module tb_multicycle_control_fsm;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b1;
    logic [6:0]  Opcode = 7'h00;
    logic        ALU_Zero = 1'b0;
    logic        Mem_Ready = 1'b0;

    logic        IR_Write, PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic        RegWrite, MemtoReg, Halted, Illegal;
    logic [15:0] Retired;

    logic        s_IR_Write, s_PC_Write, s_PC_Write_Cond, s_IorD, s_Mem_Read, s_Mem_Write;
    logic        s_ALUSrcA, s_RegWrite, s_MemtoReg, s_Halted, s_Illegal;
    logic [1:0]  s_ALUSrcB, s_ALUOp, s_PCSource;
    logic [3:0]  s_Retired;

    int errors = 0;
    int checks = 0;
    int exp_ret = 0;

    always #5 CLK = ~CLK;

    multicycle_control_fsm dut (
        .CLK(CLK), .Reset_n(Reset_n), .Opcode(Opcode), .ALU_Zero(ALU_Zero),
        .Mem_Ready(Mem_Ready), .IR_Write(IR_Write), .PC_Write(PC_Write),
        .PC_Write_Cond(PC_Write_Cond), .IorD(IorD), .Mem_Read(Mem_Read),
        .Mem_Write(Mem_Write), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .Retired(Retired), .Halted(Halted), .Illegal(Illegal)
    );

    // Same stimulus, 4-bit counter: wraps after 16 instructions instead of 65536.
    multicycle_control_fsm #(.CNT_W(4)) dut_small (
        .CLK(CLK), .Reset_n(Reset_n), .Opcode(Opcode), .ALU_Zero(ALU_Zero),
        .Mem_Ready(Mem_Ready), .IR_Write(s_IR_Write), .PC_Write(s_PC_Write),
        .PC_Write_Cond(s_PC_Write_Cond), .IorD(s_IorD), .Mem_Read(s_Mem_Read),
        .Mem_Write(s_Mem_Write), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .ALUOp(s_ALUOp),
        .PCSource(s_PCSource), .RegWrite(s_RegWrite), .MemtoReg(s_MemtoReg),
        .Retired(s_Retired), .Halted(s_Halted), .Illegal(s_Illegal)
    );

    // {IR_Write, PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, ALUSrcA,
    //  ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0], RegWrite, MemtoReg}
    logic [14:0] outs;
    assign outs = {IR_Write, PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, ALUSrcA,
                   ALUSrcB, ALUOp, PCSource, RegWrite, MemtoReg};

    localparam logic [14:0] O_FETCH_RDY  = 15'b1_1_0_0_1_0_0_01_00_00_0_0;
    localparam logic [14:0] O_FETCH_WAIT = 15'b0_0_0_0_1_0_0_01_00_00_0_0;
    localparam logic [14:0] O_DECODE     = 15'b0_0_0_0_0_0_0_10_00_00_0_0;
    localparam logic [14:0] O_EXEC_R     = 15'b0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [14:0] O_EXEC_I     = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [14:0] O_ALU_WB     = 15'b0_0_0_0_0_0_0_00_00_00_1_0;
    localparam logic [14:0] O_MEM_RD     = 15'b0_0_0_1_1_0_0_00_00_00_0_0;
    localparam logic [14:0] O_LOAD_WB    = 15'b0_0_0_0_0_0_0_00_00_00_1_1;
    localparam logic [14:0] O_MEM_WR     = 15'b0_0_0_1_0_1_0_00_00_00_0_0;
    localparam logic [14:0] O_BR_TAKEN   = 15'b0_1_1_0_0_0_1_00_01_01_0_0;
    localparam logic [14:0] O_BR_NOT     = 15'b0_0_1_0_0_0_1_00_01_01_0_0;
    localparam logic [14:0] O_JUMP       = 15'b0_1_0_0_0_0_0_00_00_10_0_0;
    localparam logic [14:0] O_NONE       = 15'b0;

    // Drive one cycle's inputs just after the falling edge; outputs are read 1 ns later.
    task automatic step(input logic mr, input logic [6:0] op, input logic z);
        @(negedge CLK);
        Mem_Ready = mr;
        Opcode    = op;
        ALU_Zero  = z;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Mem_Ready = 1'b0;
        Reset_n   = 1'b0;
        @(negedge CLK);
        Reset_n   = 1'b1;
        exp_ret   = 0;
    endtask

    task automatic test_reset();
        Mem_Ready = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({outs, Retired, Halted, Illegal} !== {O_FETCH_WAIT, 16'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: outs=%b ret=%0d h=%b i=%b, want outs=%b ret=0 h=0 i=0",
                     outs, Retired, Halted, Illegal, O_FETCH_WAIT);
        end
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
        exp_ret = 0;
    endtask

    task automatic test_rtype();
        logic [14:0] exp [4];
        exp = '{O_FETCH_RDY, O_DECODE, O_EXEC_R, O_ALU_WB};
        for (int i = 0; i < 4; i++) begin
            step(i == 0, 7'h00, 1'b0);  // Mem_Ready low after FETCH must not stall
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL rtype cycle %0d: outs=%b want %b", i, outs, exp[i]);
            end
        end
        exp_ret++;
        @(posedge CLK); #1;
        checks++;
        if (Retired !== exp_ret[15:0]) begin
            errors++;
            $display("FAIL rtype retired: got %0d want %0d", Retired, exp_ret);
        end
    endtask

    task automatic test_itype();
        logic [14:0] exp [4];
        exp = '{O_FETCH_RDY, O_DECODE, O_EXEC_I, O_ALU_WB};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 7'h1a, 1'b0);
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL itype cycle %0d: outs=%b want %b", i, outs, exp[i]);
            end
        end
        exp_ret++;
        @(posedge CLK); #1;
        checks++;
        if (Retired !== exp_ret[15:0]) begin
            errors++;
            $display("FAIL itype retired: got %0d want %0d", Retired, exp_ret);
        end
    endtask

    task automatic test_load_wait();
        logic [14:0] exp [7];
        logic [0:6]  mr;
        exp = '{O_FETCH_RDY, O_DECODE, O_EXEC_I, O_MEM_RD, O_MEM_RD, O_MEM_RD, O_LOAD_WB};
        mr  = 7'b1110011;
        for (int i = 0; i < 7; i++) begin
            step(mr[i], 7'h20, 1'b0);
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL load cycle %0d: outs=%b want %b", i, outs, exp[i]);
            end
        end
        exp_ret++;
        @(posedge CLK); #1;
        checks++;
        if (Retired !== exp_ret[15:0]) begin
            errors++;
            $display("FAIL load retired: got %0d want %0d", Retired, exp_ret);
        end
    endtask

    // FETCH wait, then store whose Opcode flips to a load encoding after DECODE.
    task automatic test_store_wait();
        logic [14:0] exp [6];
        logic [0:5]  mr;
        exp = '{O_FETCH_WAIT, O_FETCH_RDY, O_DECODE, O_EXEC_I, O_MEM_WR, O_MEM_WR};
        mr  = 6'b011101;
        for (int i = 0; i < 6; i++) begin
            step(mr[i], (i <= 2) ? 7'h30 : 7'h20, 1'b0);
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL store cycle %0d: outs=%b want %b", i, outs, exp[i]);
            end
        end
        exp_ret++;
        @(posedge CLK); #1;
        checks++;
        if (Retired !== exp_ret[15:0]) begin
            errors++;
            $display("FAIL store retired: got %0d want %0d", Retired, exp_ret);
        end
    endtask

    task automatic test_branch();
        logic [14:0] exp [3];
        for (int z = 1; z >= 0; z--) begin
            exp = '{O_FETCH_RDY, O_DECODE, (z == 1) ? O_BR_TAKEN : O_BR_NOT};
            for (int i = 0; i < 3; i++) begin
                step(1'b1, 7'h40, z[0]);
                checks++;
                if (outs !== exp[i]) begin
                    errors++;
                    $display("FAIL branch z=%0d cycle %0d: outs=%b want %b", z, i, outs, exp[i]);
                end
            end
            exp_ret++;
            @(posedge CLK); #1;
            checks++;
            if (Retired !== exp_ret[15:0]) begin
                errors++;
                $display("FAIL branch z=%0d retired: got %0d want %0d", z, Retired, exp_ret);
            end
        end
    endtask

    task automatic test_jump();
        logic [14:0] exp [3];
        exp = '{O_FETCH_RDY, O_DECODE, O_JUMP};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 7'h50, 1'b0);
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL jump cycle %0d: outs=%b want %b", i, outs, exp[i]);
            end
        end
        exp_ret++;
        @(posedge CLK); #1;
        checks++;
        if (Retired !== exp_ret[15:0]) begin
            errors++;
            $display("FAIL jump retired: got %0d want %0d", Retired, exp_ret);
        end
    endtask

    task automatic test_halt();
        step(1'b1, 7'h70, 1'b0);
        step(1'b1, 7'h70, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 7'h00, 1'b1);
            checks++;
            if ({outs, Halted, Illegal, Retired} !== {O_NONE, 1'b1, 1'b0, exp_ret[15:0]}) begin
                errors++;
                $display("FAIL halt cycle %0d: outs=%b h=%b i=%b ret=%0d, want 0 h=1 i=0 ret=%0d",
                         i, outs, Halted, Illegal, Retired, exp_ret);
            end
        end
        do_reset();
        #1;
        checks++;
        if ({Halted, Illegal, Retired} !== {1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL halt cleared by reset: h=%b i=%b ret=%0d, want 0 0 0",
                     Halted, Illegal, Retired);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [14:0] exp [4];
        exp = '{O_FETCH_RDY, O_DECODE, O_EXEC_I, O_MEM_WR};
        for (int i = 0; i < 4; i++) begin
            step(i < 3, 7'h30, 1'b0);
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: outs=%b want %b", i, outs, exp[i]);
            end
        end
        #1 Reset_n = 1'b0;
        #1;
        exp_ret = 0;
        checks++;
        if ({outs, Retired} !== {O_FETCH_WAIT, 16'h0}) begin
            errors++;
            $display("FAIL reset_mid abort: outs=%b ret=%0d, want %b ret=0",
                     outs, Retired, O_FETCH_WAIT);
        end
        @(negedge CLK);
        Reset_n = 1'b1;
    endtask

    task automatic test_illegal();
        step(1'b1, 7'h60, 1'b0);
        step(1'b1, 7'h60, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(i[0], 7'(i * 5), i[1]);
            checks++;
            if ({outs, Halted, Illegal, Retired} !== {O_NONE, 1'b1, 1'b1, exp_ret[15:0]}) begin
                errors++;
                $display("FAIL illegal cycle %0d: outs=%b h=%b i=%b ret=%0d, want 0 h=1 i=1 ret=%0d",
                         i, outs, Halted, Illegal, Retired, exp_ret);
            end
        end
    endtask

    task automatic test_retired_wrap();
        do_reset();
        for (int j = 1; j <= 16; j++) begin
            step(1'b1, 7'h50, 1'b0);
            step(1'b1, 7'h50, 1'b0);
            step(1'b1, 7'h50, 1'b0);
            @(posedge CLK); #1;
            if (j == 15) begin
                checks++;
                if (s_Retired !== 4'hf) begin
                    errors++;
                    $display("FAIL wrap pre: small retired=%0d want 15", s_Retired);
                end
            end
        end
        checks++;
        if ({s_Retired, Retired} !== {4'h0, 16'd16}) begin
            errors++;
            $display("FAIL wrap: small retired=%0d want 0, wide retired=%0d want 16",
                     s_Retired, Retired);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_load_wait();
        test_store_wait();
        test_branch();
        test_jump();
        test_halt();
        test_reset_mid_store();
        test_jump();
        test_illegal();
        test_retired_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
